// File: rtl/uart_addr_word_reader_pkg.sv
// Shared types and constants for the UART address/word reader.
package uart_addr_word_reader_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 5200;
  localparam int unsigned BYTES_PER_WORD       = 4;

  // Common encoding for the receive and transmit bit-level FSMs.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

  // Memory location X holds X mod 256, so the word at A is A..A+3 packed MSB first.
  function automatic logic [31:0] form_word(input logic [7:0] a);
    return {a, a + 8'd1, a + 8'd2, a + 8'd3};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter; a start request in the last stop-bit cycle chains the next
// frame with no idle gap.
module uart_tx_byte
  import uart_addr_word_reader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CntW-1:0] BitLast = CntW'(CLKS_PER_BIT - 1);

  uart_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            bit_end;

  assign bit_end = (cnt_q == BitLast);
  assign busy    = (state_q != StIdle);
  assign tx      = tx_q;

  // Next-state: walk start/data/stop, each bit held for exactly CLKS_PER_BIT cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (start) begin
          shift_d = data;
          state_d = StStart;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          done = 1'b1;
          if (start) begin
            shift_d = data;
            state_d = StStart;
            tx_d    = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; the line output is a flop that resets to the idle level.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/uart_addr_word_reader.sv
// UART read port: each received byte is an address A; replies with bytes A..A+3.
module uart_addr_word_reader
  import uart_addr_word_reader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Rx,
  output logic Tx
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [1:0]      LastByte = 2'(BYTES_PER_WORD - 1);

  logic            rx_meta_q, rx_sync_q;
  uart_state_e     rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_wait_q, rx_wait_d;  // framing error seen, hold off until line is high
  logic            rx_done;

  logic            seq_active_q, seq_active_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [31:0]     word_q, word_d;
  logic            tx_start, tx_busy, tx_done;
  logic [1:0]      tx_sel;
  logic [7:0]      tx_data;

  // Two-flop synchroniser; reset to the idle-high line level.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= Rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receiver next-state: half-bit start check, then mid-bit samples of data and stop.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_wait_d  = rx_wait_q;
    rx_done    = 1'b0;
    unique case (rx_state_q)
      StIdle: begin
        rx_cnt_d = '0;
        if (rx_sync_q)       rx_wait_d  = 1'b0;
        else if (!rx_wait_q) rx_state_d = StStart;
      end
      StStart: begin
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? StIdle : StData;
        end
      end
      StData: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = StStop;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      StStop: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_state_d = StIdle;
          if (rx_sync_q) rx_done   = 1'b1;
          else           rx_wait_d = 1'b1;
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  // Receiver state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_wait_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_wait_q  <= rx_wait_d;
    end
  end

  // Word sequencer: accept an address only when idle, launch byte 0, chain the rest on done.
  always_comb begin
    seq_active_d = seq_active_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    if (rx_done && !seq_active_q) begin
      seq_active_d = 1'b1;
      byte_idx_d   = '0;
      word_d       = form_word(rx_shift_q);
    end else if (tx_done) begin
      if (byte_idx_q == LastByte) seq_active_d = 1'b0;
      else                        byte_idx_d   = byte_idx_q + 2'd1;
    end
    tx_start = seq_active_q && (!tx_busy || (tx_done && byte_idx_q != LastByte));
    tx_sel   = tx_done ? byte_idx_q + 2'd1 : byte_idx_q;
    unique case (tx_sel)
      2'd0:    tx_data = word_q[31:24];
      2'd1:    tx_data = word_q[23:16];
      2'd2:    tx_data = word_q[15:8];
      default: tx_data = word_q[7:0];
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      seq_active_q <= 1'b0;
      byte_idx_q   <= '0;
      word_q       <= '0;
    end else begin
      seq_active_q <= seq_active_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .start(tx_start),
    .data (tx_data),
    .busy (tx_busy),
    .done (tx_done),
    .tx   (Tx)
  );

endmodule

// File: tb/tb_uart_addr_word_reader.sv
// Bench for uart_addr_word_reader: drives UART frames, decodes Tx frames and checks
// them against a queue of expected bytes built from the address/memory rules.
module tb_uart_addr_word_reader;

  localparam int unsigned CPB = 16;
  localparam int unsigned H   = CPB / 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic rx    = 1'b1;
  logic tx;
  bit   clk_en = 1'b0;

  int unsigned cyc = 0;
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  typedef struct {
    logic [7:0]  b;
    bit          first;
    int unsigned stop_cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  got_log[$];
  int unsigned busy_until = 0;

  uart_addr_word_reader #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .Clk  (clk),
    .Rst_n(rst_n),
    .Rx   (rx),
    .Tx   (tx)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, got, exp);
  endtask

  // Reply word for address a: byte i is memory location a+i, which holds (a+i) mod 256.
  function automatic logic [31:0] model_word(input logic [7:0] a);
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < 4; i++) w = (w << 8) | 32'((int'(a) + i) % 256);
    return w;
  endfunction

  // A good byte is answered only if the previous reply has finished; otherwise dropped.
  task automatic model_rx(input logic [7:0] a, input int unsigned stop_cyc);
    logic [31:0] w;
    exp_t        e;
    if (stop_cyc + H + 3 >= busy_until) begin
      w = model_word(a);
      for (int i = 0; i < 4; i++) begin
        e.b        = w[31-8*i -: 8];
        e.first    = (i == 0);
        e.stop_cyc = stop_cyc;
        exp_q.push_back(e);
      end
      busy_until = stop_cyc + H + 4 + 40 * CPB;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int unsigned stop_cyc);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx       = stop;
    stop_cyc = cyc;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] a);
    int unsigned sc;
    send_frame(a, 1'b1, sc);
    model_rx(a, sc);
  endtask

  task automatic drain(input string name);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 60 * CPB) begin
      @(negedge clk);
      n++;
    end
    repeat (2 * CPB) @(negedge clk);
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_log(input string name, input logic [31:0] w);
    chk({name, "_count"}, 32'(got_log.size()), 32'd4);
    if (got_log.size() >= 4)
      for (int i = 0; i < 4; i++) chk({name, "_byte"}, 32'(got_log[i]), 32'(w[31-8*i -: 8]));
    got_log.delete();
  endtask

  task automatic quiet(input string name, input int unsigned n);
    repeat (n) @(negedge clk);
    chk(name, 32'(got_log.size()), 32'd0);
    got_log.delete();
  endtask

  task automatic wait_tx_low(input string name, input int unsigned budget);
    bit found;
    found = 1'b0;
    for (int unsigned i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (tx === 1'b0) found = 1'b1;
    end
    chk(name, 32'(found), 32'd1);
  endtask

  task automatic mon_wait(input int unsigned n, inout bit ab);
    repeat (n) begin
      @(negedge clk);
      if (rst_n !== 1'b1) ab = 1'b1;
    end
  endtask

  // Compare process: decode every Tx frame mid-bit and check it against the model queue.
  initial begin : monitor
    logic [7:0]  got;
    logic        s_start, s_stop;
    bit          ab;
    int unsigned fall, last_fall, lat;
    exp_t        e;
    last_fall = 0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        fall = cyc;
        ab   = 1'b0;
        mon_wait(H, ab);
        s_start = tx;
        for (int i = 0; i < 8; i++) begin
          mon_wait(CPB, ab);
          got[i] = tx;
        end
        mon_wait(CPB, ab);
        s_stop = tx;
        if (!ab) begin
          got_log.push_back(got);
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_frame: got byte %0h, required no frame", got);
          end else begin
            e = exp_q.pop_front();
            chk("start_bit", 32'(s_start), 32'd0);
            chk("frame_byte", 32'(got), 32'(e.b));
            chk("stop_bit", 32'(s_stop), 32'd1);
            if (e.first) begin
              lat = fall - e.stop_cyc;
              chk("reply_latency_in_window", 32'(lat >= H + 2 && lat <= H + 6), 32'd1);
            end else begin
              chk("back_to_back_start", fall, last_fall + 10 * CPB);
            end
          end
          last_fall = fall;
          mon_wait(H - 1, ab);
        end
        while (rst_n !== 1'b1) @(negedge clk);
      end
    end
  end

  initial begin : stimulus
    int unsigned sc;
    int unsigned bad;
    logic [7:0]  a;

    // Reset applied with the clock stopped.
    #2 rst_n = 1'b0;
    #5 chk("reset_tx_clock_stopped", 32'(tx), 32'd1);
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_tx_clock_running", 32'(tx), 32'd1);
    rst_n = 1'b1;
    bad = 0;
    repeat (4 * CPB) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    chk("idle_after_reset_low_cycles", bad, 32'd0);

    // Model pins.
    chk("model_word_02", model_word(8'h02), 32'h02030405);
    chk("model_word_fe", model_word(8'hFE), 32'hFEFF0001);

    // Single address.
    send_byte(8'h02);
    drain("resp_02_drained");
    check_log("log_02", 32'h02030405);

    // Address sweep with long gaps.
    for (int k = 0; k < 8; k++) begin
      a = 8'h02 + 8'(32 * k);
      send_byte(a);
      drain("sweep_drained");
      check_log("log_sweep", model_word(a));
    end

    // Wrap-around.
    send_byte(8'hFE);
    drain("resp_fe_drained");
    check_log("log_fe", 32'hFEFF0001);

    // Framing error, glitch, and a line held low are all ignored.
    send_frame(8'h5A, 1'b0, sc);
    quiet("framing_error_no_tx", 50 * CPB);
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    quiet("glitch_no_tx", 50 * CPB);
    rx = 1'b0;
    repeat (30 * CPB) @(negedge clk);
    rx = 1'b1;
    quiet("held_low_no_tx", 50 * CPB);

    send_byte(8'h7C);
    drain("resp_7c_drained");
    check_log("log_7c", 32'h7C7D7E7F);

    // Second address while a reply is in flight is dropped.
    send_byte(8'h10);
    repeat (5 * CPB) @(negedge clk);
    send_byte(8'h55);
    drain("resp_10_drained");
    check_log("log_10_with_drop", 32'h10111213);
    quiet("dropped_byte_no_reply", 50 * CPB);

    // Reset in the middle of a reply.
    send_byte(8'h30);
    wait_tx_low("reply_30_started", 20 * CPB);
    repeat (12 * CPB) @(negedge clk);
    wait_tx_low("reply_31_low_bit", 4 * CPB);
    #2 rst_n = 1'b0;
    exp_q.delete();
    busy_until = 0;
    #1 chk("reset_mid_reply_tx", 32'(tx), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (60 * CPB) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    chk("post_reset_low_cycles", bad, 32'd0);
    chk("post_reset_frames_seen", 32'(got_log.size()), 32'd1);
    got_log.delete();

    // Normal operation after the reset.
    send_byte(8'h20);
    drain("resp_20_drained");
    check_log("log_20", 32'h20212223);

    repeat (20 * CPB) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
